bpf_cal_ctrl: RTL and testbench
===============================

Name: bpf_cal_ctrl

Overview:
- Calibration sequencer that drives the band-pass filter's power-up/calibrate interface (PU_BPF, CAL_BPF) and consumes its ready flag (RDY_BPF).
- Powers the filter up, waits a settle time, requests calibration, and waits for ready with a timeout.
- Power-cycles and retries on timeout; reports locked/busy/error status to the top-level control FSM.

Parameters:
- SETTLE_CYC, 16: cycles PU_BPF is high before CAL_BPF asserts (≥1).
- TIMEOUT_CYC, 2048: maximum cycles in CAL waiting for RDY_BPF (≥1).
- OFF_CYC, 8: cycles PU_BPF is held low between attempts (≥1).
- RETRY_MAX, 2: extra attempts after the first timeout (0..3).
- CNT_W, 12: counter width; must hold max(SETTLE_CYC, TIMEOUT_CYC, OFF_CYC).

Ports:
- CLK  in  1  system clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  calibration request, sampled per cycle.
- ABORT  in  1  forces power-down and return to IDLE.
- RDY_BPF  in  1  filter ready, synchronous to CLK.
- PU_BPF  out  1  filter power-up.
- CAL_BPF  out  1  filter calibrate request.
- BUSY  out  1  high in PWRUP, CAL and OFF.
- DONE  out  1  high in LOCKED.
- ERR  out  1  high in FAIL.
- RETRIES  out  2  attempts consumed so far.

Behaviour:
- Reset (RSTN low, async): state IDLE; PU_BPF=0, CAL_BPF=0, BUSY=0, DONE=0, ERR=0, RETRIES=0, counter=0. Release is synchronous to the next CLK edge.
- All outputs are registered and decoded from the state.
- IDLE: PU=0, CAL=0.
  - START=1 at edge n → PWRUP, counter cleared, RETRIES=0.
  - PU_BPF=1 after edge n.
- PWRUP: PU=1, CAL=0.
  - Lasts exactly SETTLE_CYC cycles, then → CAL.
  - CAL_BPF=1 after edge n+SETTLE_CYC.
  - RDY_BPF is ignored in this state.
- CAL: PU=1, CAL=1. Counter counts cycles in CAL.
  - RDY_BPF sampled high at edge m (within the first TIMEOUT_CYC edges) → LOCKED. CAL_BPF=0 and DONE=1 after edge m.
  - Counter reaches TIMEOUT_CYC with RDY low:
    - RETRIES<RETRY_MAX → OFF, RETRIES++.
    - Otherwise → FAIL.
- OFF: PU=0, CAL=0, for exactly OFF_CYC cycles, then → PWRUP. Dropping PU clears the filter's RDY.
- LOCKED: PU=1, CAL=0, DONE=1.
  - START → OFF with RETRIES cleared (recalibration; RDY can only clear via PU low).
- FAIL: PU=0, CAL=0, ERR=1.
  - START → PWRUP with ERR cleared and RETRIES=0.
- START in PWRUP, CAL or OFF is ignored.
- ABORT=1 in any state → IDLE on that edge, with PU/CAL/DONE/ERR/BUSY=0 and RETRIES=0.
- ABORT and START high in the same cycle: ABORT wins.
- Counter saturates, never wraps. Cleared on every state change.
- RDY_BPF falling in LOCKED: no effect unless the optional feature is enabled.

Optional Feature:
- Macro: BPF_LOCK_MON_EN.
- Defined:
  - In LOCKED, RDY_BPF sampled low → OFF with RETRIES++, DONE=0 next cycle.
  - If RETRIES already equals RETRY_MAX → FAIL instead.
- Undefined: LOCKED is left only by START, ABORT or reset.

Test Plan:
- Nominal lock: reset, pulse START; filter model raises RDY 1000 cycles after CAL.
  - PU=1 one cycle after START; CAL=1 16 cycles later.
  - DONE=1 and CAL=0 one cycle after RDY seen; RETRIES=0, ERR=0.
- Single retry: RDY held low during the first attempt, responds on the second.
  - CAL drops at 2048 cycles; PU=0 for 8 cycles; RETRIES=1.
  - Second attempt locks; DONE=1.
- Exhaust: RDY never high. Three CAL windows of 2048 cycles each, then ERR=1, PU=0, RETRIES=2.
  - START afterwards → ERR=0, PU=1, RETRIES=0.
- Abort mid-CAL: ABORT at cycle 500 of CAL → next cycle PU=0, CAL=0, BUSY=0, IDLE.
  - ABORT+START together in IDLE → stays IDLE, PU=0.
- Async reset mid-PWRUP: RSTN low between edges → all outputs 0 immediately without a clock edge.
  - Release, then START → sequence restarts cleanly.
- Recal from LOCKED: START in LOCKED → PU=0 for 8 cycles, then re-lock.
  - With BPF_LOCK_MON_EN, forcing RDY low in LOCKED → DONE=0 next cycle and OFF entered.

Source files
------------

// File: rtl/bpf_cal_ctrl.sv
// bpf_cal_ctrl: band-pass filter power-up / calibration sequencer with timeout and retry
//
// Powers the filter up, waits SETTLE_CYC cycles, then requests calibration.
// It waits up to TIMEOUT_CYC cycles for ready. On a timeout it power-cycles
// the filter for OFF_CYC cycles and retries, at most RETRY_MAX extra times.
// If every attempt times out, the sequencer stops in FAIL.
//
// Optional build macro BPF_LOCK_MON_EN: while LOCKED, a low RDY is treated
// as a lost lock and triggers a power-cycle retry (or FAIL once retries are used up).
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_start     calibration request (IDLE, LOCKED, FAIL)
//   i_abort     forces power-down and return to IDLE; overrides i_start
//   i_rdy_bpf   filter ready, synchronous to i_clk
//   o_pu_bpf    filter power-up
//   o_cal_bpf   filter calibrate request
//   o_busy      high in PWRUP, CAL and OFF
//   o_done      high in LOCKED
//   o_err       high in FAIL
//   o_retries   attempts consumed so far
module bpf_cal_ctrl #(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 2048,
    parameter int OFF_CYC     = 8,
    parameter int RETRY_MAX   = 2,
    parameter int CNT_W       = 12
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_rdy_bpf,
    output logic       o_pu_bpf,
    output logic       o_cal_bpf,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [1:0] o_retries
);
    typedef enum logic [2:0] {S_IDLE, S_PWRUP, S_CAL, S_OFF, S_LOCKED, S_FAIL} state_t;

    // The counter holds the number of edges already spent in the state.
    // A state that lasts N cycles is therefore left when the counter reads N-1.
    localparam logic [CNT_W-1:0] L_SET  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] L_TO   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] L_OFF  = CNT_W'(OFF_CYC - 1);
    localparam logic [1:0]       L_RMAX = 2'(RETRY_MAX);

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [1:0]       r_retries, w_retries_nx;
    logic             r_pu, r_cal, r_busy, r_done, r_err;

    always_comb begin
        w_state_nx   = r_state;
        w_retries_nx = r_retries;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nx   = S_PWRUP;
                    w_retries_nx = '0;
                end
            end
            S_PWRUP: begin
                if (r_cnt == L_SET) w_state_nx = S_CAL;
            end
            S_CAL: begin
                // Ready on the final window edge still counts as a lock.
                if (i_rdy_bpf) begin
                    w_state_nx = S_LOCKED;
                end else if (r_cnt == L_TO) begin
                    if (r_retries < L_RMAX) begin
                        w_state_nx   = S_OFF;
                        w_retries_nx = r_retries + 2'd1;
                    end else begin
                        w_state_nx = S_FAIL;
                    end
                end
            end
            S_OFF: begin
                if (r_cnt == L_OFF) w_state_nx = S_PWRUP;
            end
            S_LOCKED: begin
                // Recalibration goes through OFF, because RDY only clears while PU is low.
                if (i_start) begin
                    w_state_nx   = S_OFF;
                    w_retries_nx = '0;
                end
`ifdef BPF_LOCK_MON_EN
                else if (!i_rdy_bpf) begin
                    if (r_retries == L_RMAX) begin
                        w_state_nx = S_FAIL;
                    end else begin
                        w_state_nx   = S_OFF;
                        w_retries_nx = r_retries + 2'd1;
                    end
                end
`endif
            end
            S_FAIL: begin
                if (i_start) begin
                    w_state_nx   = S_PWRUP;
                    w_retries_nx = '0;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (i_abort) begin
            w_state_nx   = S_IDLE;
            w_retries_nx = '0;
        end
        w_cnt_nx = (w_state_nx != r_state) ? '0 : (&r_cnt ? r_cnt : r_cnt + 1'b1);
    end

    // Outputs are registered from the next state, so they change on the same edge as the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_retries <= '0;
            r_pu      <= 1'b0;
            r_cal     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_retries <= w_retries_nx;
            r_pu      <= (w_state_nx == S_PWRUP) || (w_state_nx == S_CAL) || (w_state_nx == S_LOCKED);
            r_cal     <= (w_state_nx == S_CAL);
            r_busy    <= (w_state_nx == S_PWRUP) || (w_state_nx == S_CAL) || (w_state_nx == S_OFF);
            r_done    <= (w_state_nx == S_LOCKED);
            r_err     <= (w_state_nx == S_FAIL);
        end
    end

    assign o_pu_bpf  = r_pu;
    assign o_cal_bpf = r_cal;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_retries = r_retries;
endmodule

// File: tb/tb_bpf_cal_ctrl.sv
// tb_bpf_cal_ctrl: directed scoreboard bench for bpf_cal_ctrl
module tb_bpf_cal_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       rdy = 1'b0;
    logic       pu, cal, busy, done, err;
    logic [1:0] retries;
    logic [6:0] obs;

    int errors = 0;
    int checks = 0;

    string      tag_q[$];
    logic [6:0] exp_q[$];

    // {pu, cal, busy, done, err}
    localparam logic [4:0] P_IDLE = 5'b00000;
    localparam logic [4:0] P_PU   = 5'b10100;
    localparam logic [4:0] P_CAL  = 5'b11100;
    localparam logic [4:0] P_OFF  = 5'b00100;
    localparam logic [4:0] P_LCK  = 5'b10010;
    localparam logic [4:0] P_FL   = 5'b00001;

    bpf_cal_ctrl dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_abort   (abort),
        .i_rdy_bpf (rdy),
        .o_pu_bpf  (pu),
        .o_cal_bpf (cal),
        .o_busy    (busy),
        .o_done    (done),
        .o_err     (err),
        .o_retries (retries)
    );

    always #5 clk = ~clk;

    assign obs = {pu, cal, busy, done, err, retries};

    // Pushes the expectation, advances n rising edges, then pops and compares at the falling edge.
    task automatic step(input int n, input string tag, input logic [4:0] f, input logic [1:0] r);
        string      t;
        logic [6:0] e;
        tag_q.push_back(tag);
        exp_q.push_back({f, r});
        if (n > 0) begin
            repeat (n) @(posedge clk);
            @(negedge clk);
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed pu,cal,busy,done,err,retries=%b expected=%b", t, obs, e);
        end
    endtask

    initial begin
        #2;
        step(0, "reset_state", P_IDLE, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3, "idle_hold", P_IDLE, 2'd0);

        start = 1'b1;
        step(1, "nom_pu_after_start", P_PU, 2'd0);
        start = 1'b0;
        step(15, "nom_pwrup_settle", P_PU, 2'd0);
        step(1, "nom_cal_after_16", P_CAL, 2'd0);
        step(999, "nom_cal_waiting", P_CAL, 2'd0);
        rdy = 1'b1;
        step(1, "nom_locked", P_LCK, 2'd0);
        step(5, "nom_locked_hold", P_LCK, 2'd0);

        start = 1'b1;
        step(1, "recal_off", P_OFF, 2'd0);
        start = 1'b0;
        rdy = 1'b0;
        step(7, "recal_off_hold", P_OFF, 2'd0);
        step(1, "recal_pwrup", P_PU, 2'd0);
        start = 1'b1;
        step(1, "start_ignored_pwrup", P_PU, 2'd0);
        start = 1'b0;
        step(14, "recal_pwrup_end", P_PU, 2'd0);
        step(1, "recal_cal", P_CAL, 2'd0);
        step(10, "recal_cal_wait", P_CAL, 2'd0);
        rdy = 1'b1;
        step(1, "recal_relock", P_LCK, 2'd0);

        abort = 1'b1;
        step(1, "abort_locked", P_IDLE, 2'd0);
        abort = 1'b0;
        rdy = 1'b0;

        start = 1'b1;
        step(1, "retry_pwrup", P_PU, 2'd0);
        start = 1'b0;
        step(16, "retry_cal1", P_CAL, 2'd0);
        step(2047, "retry_cal1_last", P_CAL, 2'd0);
        step(1, "retry_off", P_OFF, 2'd1);
        step(7, "retry_off_hold", P_OFF, 2'd1);
        step(1, "retry_pwrup2", P_PU, 2'd1);
        step(16, "retry_cal2", P_CAL, 2'd1);
        step(5, "retry_cal2_wait", P_CAL, 2'd1);
        rdy = 1'b1;
        step(1, "retry_locked", P_LCK, 2'd1);
        abort = 1'b1;
        step(1, "abort_after_retry", P_IDLE, 2'd0);
        abort = 1'b0;
        rdy = 1'b0;

        start = 1'b1;
        step(1, "exh_pwrup1", P_PU, 2'd0);
        start = 1'b0;
        step(16, "exh_cal1", P_CAL, 2'd0);
        step(2048, "exh_off1", P_OFF, 2'd1);
        step(8, "exh_pwrup2", P_PU, 2'd1);
        step(16, "exh_cal2", P_CAL, 2'd1);
        step(2048, "exh_off2", P_OFF, 2'd2);
        step(8, "exh_pwrup3", P_PU, 2'd2);
        step(16, "exh_cal3", P_CAL, 2'd2);
        step(2047, "exh_cal3_last", P_CAL, 2'd2);
        step(1, "exh_fail", P_FL, 2'd2);
        step(4, "exh_fail_hold", P_FL, 2'd2);
        start = 1'b1;
        step(1, "fail_restart", P_PU, 2'd0);
        start = 1'b0;

        step(16, "abort_cal_enter", P_CAL, 2'd0);
        step(500, "abort_cal_500", P_CAL, 2'd0);
        abort = 1'b1;
        step(1, "abort_mid_cal", P_IDLE, 2'd0);
        start = 1'b1;
        step(1, "abort_start_idle", P_IDLE, 2'd0);
        abort = 1'b0;
        start = 1'b0;

        start = 1'b1;
        step(1, "arst_pwrup", P_PU, 2'd0);
        start = 1'b0;
        step(5, "arst_pwrup_hold", P_PU, 2'd0);
        #2 rst_n = 1'b0;
        #1 step(0, "arst_immediate", P_IDLE, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2, "arst_idle_after", P_IDLE, 2'd0);
        start = 1'b1;
        step(1, "arst_restart", P_PU, 2'd0);
        start = 1'b0;
        step(16, "arst_cal", P_CAL, 2'd0);
        rdy = 1'b1;
        step(1, "mon_locked", P_LCK, 2'd0);
        rdy = 1'b0;
`ifdef BPF_LOCK_MON_EN
        step(1, "mon_lost_lock_off", P_OFF, 2'd1);
`else
        step(3, "mon_disabled_hold", P_LCK, 2'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
